vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing on vga_clk (25 MHz pixel clock).
- Drives the DrawX/DrawY/blank inputs of every sprite/background mapper.
- Supplies hsync/vsync to the pins, delayed to match the mappers' 2-cycle ROM + output-register latency.
- Provides frame/line strobes and a frame counter for animation sequencing.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DELAY, 2, sync/blank delay stages for the pin outputs; legal range 0..4

Ports:
vga_clk  in  1  pixel clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
DrawX  out  10  current horizontal count, 0..H_TOTAL-1 (H_TOTAL=800)
DrawY  out  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL=525)
blank  out  1  1 = (DrawX,DrawY) visible; 0 = blanking; same cycle as DrawX/DrawY
hs  out  1  active-low hsync, aligned with DrawX/DrawY
vs  out  1  active-low vsync, aligned with DrawX/DrawY
hs_d  out  1  hs delayed PIPE_DELAY clocks (to pin)
vs_d  out  1  vs delayed PIPE_DELAY clocks (to pin)
blank_d  out  1  blank delayed PIPE_DELAY clocks (DAC blanking)
line_start  out  1  one-cycle pulse when DrawX wraps to 0
frame_start  out  1  one-cycle pulse when (DrawX,DrawY) wraps to (0,0)
frame_count  out  16  completed-frame counter

Behaviour:
- Counters:
  - DrawX increments every clock.
  - At DrawX=H_TOTAL-1, DrawX goes to 0 and DrawY increments.
  - At (H_TOTAL-1, V_TOTAL-1), both go to 0.
  - Widths: 10 bits; no counter ever exceeds its TOTAL-1.
- Decodes, all registered and valid in the same cycle as the DrawX/DrawY they describe (implement from next-count values):
  - blank = (DrawX<H_VISIBLE) && (DrawY<V_VISIBLE).
  - hs = 0 iff DrawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751].
  - vs = 0 iff DrawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] = [490,491], for every DrawX of those lines.
- Strobes:
  - line_start = 1 only in the cycle DrawX=0 reached by a wrap from H_TOTAL-1.
  - frame_start = 1 only in the cycle (0,0) reached by a wrap from (799,524).
  - frame_start implies line_start.
  - Neither strobe asserts in the first cycle after reset release.
- frame_count: increments by 1 in the same cycle frame_start asserts; wraps 0xFFFF -> 0x0000.
- Delay line:
  - hs_d/vs_d/blank_d are shift registers of depth PIPE_DELAY.
  - PIPE_DELAY=0 means combinational passthrough of hs/vs/blank.
- Reset (asynchronous, reset_n=0), values held while low:
  - DrawX=0, DrawY=0, blank=1, hs=1, vs=1.
  - hs_d=1, vs_d=1, blank_d=0 for all stages.
  - line_start=0, frame_start=0, frame_count=0.
- Reset release: first clock edge after reset_n rises advances DrawX to 1; timing proceeds normally.
- Reset asserted mid-frame or mid-sync: all outputs jump immediately (no clock needed) to reset values; no partial sync pulse is extended.
- Frame length is exactly 800*525 = 420000 clocks; hs period 800 clocks; vs low for exactly 1600 clocks.

Test Plan:
- Reset then run 1 line -> DrawX sequence 0,1..799,0. hs low for DrawX 656..751 only (96 clocks). line_start high once at the wrap. blank high for DrawX 0..639 while DrawY=0.
- Run a full frame -> frame_start pulses exactly 420000 clocks apart. frame_count 0->1 on first pulse. No strobe in the first cycle after reset.
- Vertical check -> vs low from (0,490) through (799,491), 1600 clocks. blank 0 for all DrawY 480..524 regardless of DrawX.
- PIPE_DELAY=2 -> hs_d/vs_d/blank_d equal hs/vs/blank from 2 clocks earlier, checked at every edge of a sync pulse. PIPE_DELAY=0 -> equal same-cycle.
- Assert reset_n=0 at DrawX=700, DrawY=491 (inside hs and vs) -> hs=vs=1, DrawX=DrawY=0, blank_d=0 before the next clock edge. After release, timing restarts from (0,0).
- Preload/force frame_count to 0xFFFF, run to frame end -> frame_count=0x0000 in the frame_start cycle.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing generator.
// Produces the DrawX/DrawY scan position, visible-area flag, active-low
// h/v sync and line/frame strobes, all registered and aligned with the
// DrawX/DrawY they describe. A configurable delay line re-times
// sync/blank for the pins so they line up with the sprite mappers'
// ROM and output-register latency. A 16-bit counter tracks completed
// frames for animation sequencing.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        hs_d,
  output logic        vs_d,
  output logic        blank_d,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Counter limits and decode windows expressed at counter width.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        vis_q, vis_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        lstart_q, lstart_d;
  logic        fstart_q, fstart_d;
  logic [15:0] fcount_q, fcount_d;

  // Next scan position: X wraps at the end of a line, Y at the end of a frame.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = 10'd0;
      if (y_q == V_LAST) begin
        y_d = 10'd0;
      end else begin
        y_d = y_q + 10'd1;
      end
    end else begin
      x_d = x_q + 10'd1;
    end
  end

  // Decode the next position so the registered flags line up with DrawX/DrawY.
  always_comb begin
    vis_d   = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    // Strobes fire only on a real wrap, never on the post-reset (0,0).
    lstart_d = (x_q == H_LAST);
    fstart_d = (x_q == H_LAST) && (y_q == V_LAST);
    if (fstart_d) begin
      fcount_d = fcount_q + 16'd1;
    end else begin
      fcount_d = fcount_q;
    end
  end

  // Raster state and aligned decodes; reset parks the scan at (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      vis_q    <= 1'b1;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
      fcount_q <= 16'd0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      vis_q    <= vis_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
      fcount_q <= fcount_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = vis_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign line_start  = lstart_q;
  assign frame_start = fstart_q;
  assign frame_count = fcount_q;

  // Pin-side delay line matching the mapper pipeline depth.
  if (PIPE_DELAY == 0) begin : g_pass
    assign hs_d    = hsync_q;
    assign vs_d    = vsync_q;
    assign blank_d = vis_q;
  end else begin : g_pipe
    logic [PIPE_DELAY-1:0] hs_pipe_q;
    logic [PIPE_DELAY-1:0] vs_pipe_q;
    logic [PIPE_DELAY-1:0] blank_pipe_q;

    // Shift sync/blank through PIPE_DELAY stages; reset drives syncs
    // inactive and the DAC blanked so no partial pulse leaves the pins.
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe_q    <= {PIPE_DELAY{1'b1}};
        vs_pipe_q    <= {PIPE_DELAY{1'b1}};
        blank_pipe_q <= {PIPE_DELAY{1'b0}};
      end else begin
        hs_pipe_q[0]    <= hsync_q;
        vs_pipe_q[0]    <= vsync_q;
        blank_pipe_q[0] <= vis_q;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          hs_pipe_q[i]    <= hs_pipe_q[i-1];
          vs_pipe_q[i]    <= vs_pipe_q[i-1];
          blank_pipe_q[i] <= blank_pipe_q[i-1];
        end
      end
    end

    assign hs_d    = hs_pipe_q[PIPE_DELAY-1];
    assign vs_d    = vs_pipe_q[PIPE_DELAY-1];
    assign blank_d = blank_pipe_q[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance with a 2-stage pin
// delay, and a miniature 16x8 raster with passthrough delay for frame-level
// behaviour (strobe spacing, vsync, frame counter wrap).
module tb_vga_timing_gen;

  logic clk;
  logic rst_a, rst_b;

  logic [9:0]  DrawX_a, DrawY_a, DrawX_b, DrawY_b;
  logic        blank_a, hs_a, vs_a, hs_d_a, vs_d_a, blank_d_a, ls_a, fs_a;
  logic        blank_b, hs_b, vs_b, hs_d_b, vs_d_b, blank_d_b, ls_b, fs_b;
  logic [15:0] fc_a, fc_b;

  int total = 0;
  int bad   = 0;

  vga_timing_gen #(.PIPE_DELAY(2)) dut_a (
    .vga_clk(clk), .reset_n(rst_a),
    .DrawX(DrawX_a), .DrawY(DrawY_a), .blank(blank_a), .hs(hs_a), .vs(vs_a),
    .hs_d(hs_d_a), .vs_d(vs_d_a), .blank_d(blank_d_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  // Miniature raster: H 8+2+3+3=16 (hs low x=10..12), V 4+1+2+1=8 (vs low y=5..6).
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DELAY(0)
  ) dut_b (
    .vga_clk(clk), .reset_n(rst_b),
    .DrawX(DrawX_b), .DrawY(DrawY_b), .blank(blank_b), .hs(hs_b), .vs(vs_b),
    .hs_d(hs_d_b), .vs_d(vs_d_b), .blank_d(blank_d_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int in_rng(input int v, input int lo, input int hi);
    return (v >= lo && v <= hi) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full-size instance, k clocks after reset release.
  task automatic check_a(input int k);
    int x, y, xx, yy;
    x = k % 800;
    y = (k / 800) % 525;
    chk("a_x", DrawX_a, x);
    chk("a_y", DrawY_a, y);
    chk("a_blank", blank_a, (x < 640 && y < 480) ? 1 : 0);
    chk("a_hs", hs_a, 1 - in_rng(x, 656, 751));
    chk("a_vs", vs_a, 1 - in_rng(y, 490, 491));
    chk("a_ls", ls_a, (k > 0 && x == 0) ? 1 : 0);
    chk("a_fs", fs_a, (k > 0 && x == 0 && y == 0) ? 1 : 0);
    chk("a_fc", fc_a, k / 420000);
    if (k >= 2) begin
      xx = (k - 2) % 800;
      yy = ((k - 2) / 800) % 525;
      chk("a_hs_d", hs_d_a, 1 - in_rng(xx, 656, 751));
      chk("a_vs_d", vs_d_a, 1 - in_rng(yy, 490, 491));
      chk("a_blank_d", blank_d_a, (xx < 640 && yy < 480) ? 1 : 0);
    end else begin
      chk("a_hs_d_rst", hs_d_a, 1);
      chk("a_vs_d_rst", vs_d_a, 1);
      chk("a_blank_d_rst", blank_d_a, 0);
    end
  endtask

  // Miniature instance, k clocks after reset release (passthrough delay).
  task automatic check_b(input int k);
    int x, y, eh, ev, eb;
    x  = k % 16;
    y  = (k / 16) % 8;
    eh = 1 - in_rng(x, 10, 12);
    ev = 1 - in_rng(y, 5, 6);
    eb = (x < 8 && y < 4) ? 1 : 0;
    chk("b_x", DrawX_b, x);
    chk("b_y", DrawY_b, y);
    chk("b_blank", blank_b, eb);
    chk("b_hs", hs_b, eh);
    chk("b_vs", vs_b, ev);
    chk("b_ls", ls_b, (k > 0 && x == 0) ? 1 : 0);
    chk("b_fs", fs_b, (k > 0 && x == 0 && y == 0) ? 1 : 0);
    chk("b_fc", fc_b, k / 128);
    chk("b_hs_d", hs_d_b, eh);
    chk("b_vs_d", vs_d_b, ev);
    chk("b_blank_d", blank_d_b, eb);
  endtask

  initial begin
    int hs_low_cnt, ls_cnt, vs_low_cnt, fs_prev, fs_gap, kb, found;
    hs_low_cnt = 0;
    ls_cnt     = 0;
    vs_low_cnt = 0;
    fs_prev    = -1;
    fs_gap     = 0;
    found      = 0;

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check_a(0);
    check_b(0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Three lines on the full raster, ending at DrawX=700 of line 2.
    for (int k = 1; k <= 2300; k++) begin
      step();
      check_a(k);
      if (k <= 800 && hs_a == 1'b0) hs_low_cnt++;
      if (ls_a) ls_cnt++;
      if (k <= 1700) begin
        check_b(k);
        if (k <= 128 && vs_b == 1'b0) vs_low_cnt++;
        if (fs_b) begin
          if (fs_prev >= 0) fs_gap = k - fs_prev;
          fs_prev = k;
        end
      end
    end
    chk("a_hs_low_clocks", hs_low_cnt, 96);
    chk("a_line_start_count", ls_cnt, 2);
    chk("b_vs_low_clocks", vs_low_cnt, 32);
    chk("b_frame_gap", fs_gap, 128);

    // Reset mid-hsync on the full raster: outputs must drop without a clock.
    chk("a_pre_rst_hs", hs_a, 0);
    rst_a = 1'b0;
    #1;
    chk("a_mid_rst_x", DrawX_a, 0);
    chk("a_mid_rst_y", DrawY_a, 0);
    chk("a_mid_rst_hs", hs_a, 1);
    chk("a_mid_rst_vs", vs_a, 1);
    chk("a_mid_rst_blank_d", blank_d_a, 0);
    chk("a_mid_rst_hs_d", hs_d_a, 1);
    @(negedge clk);

    // Walk the miniature raster to x=11,y=5 (inside both syncs), then reset.
    kb = 2301;
    for (int n = 0; n < 200 && (kb % 128) != 91; n++) begin
      step();
      kb++;
    end
    chk("b_pre_rst_hs", hs_b, 0);
    chk("b_pre_rst_vs", vs_b, 0);
    rst_b = 1'b0;
    #1;
    chk("b_mid_rst_x", DrawX_b, 0);
    chk("b_mid_rst_y", DrawY_b, 0);
    chk("b_mid_rst_hs", hs_b, 1);
    chk("b_mid_rst_vs", vs_b, 1);
    chk("b_mid_rst_fc", fc_b, 0);
    @(negedge clk);

    // Release both; timing must restart from (0,0) with no early strobe.
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      check_a(j);
      check_b(j);
    end

    // Frame counter wrap: preload 0xFFFF, expect 0x0000 with frame_start.
    force dut_b.fcount_q = 16'hFFFF;
    step();
    release dut_b.fcount_q;
    chk("b_fc_preload", fc_b, 16'hFFFF);
    for (int n = 0; n < 300; n++) begin
      step();
      if (fs_b) begin
        found = 1;
        chk("b_fc_wrap", fc_b, 0);
        chk("b_fs_implies_ls", ls_b, 1);
        chk("b_wrap_x", DrawX_b, 0);
        chk("b_wrap_y", DrawY_b, 0);
        break;
      end
    end
    chk("b_fc_wrap_seen", found, 1);
    step();
    chk("b_fc_hold", fc_b, 0);
    chk("b_fs_one_cycle", fs_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
